multi_button_debounce: RTL and testbench

Parametrised N-channel push-button conditioner that replaces the single-button cleanup block in the calculator front end. Each channel has its own input synchroniser, debounce FSM and timer. It produces one-cycle press and release strobes, a debounced level, and optional hold-to-repeat strobes. A priority encoder reports the lowest-index pressed key so the keypad decoder consumes one code per cycle.

---
 rtl/multi_button_debounce.sv | 154 +++++++++++++++
 tb/tb_multi_button_debounce.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/multi_button_debounce.sv
// N-channel push-button conditioner: per-channel synchroniser, debounce FSM and
// hold-to-repeat timer, with a lowest-index priority encoder on the press strobes.
module multi_button_debounce #(
    parameter int             N               = 5,
    parameter int             DEBOUNCE_CYCLES = 40000,
    parameter int             REPEAT_DELAY    = 2500000,
    parameter int             REPEAT_PERIOD   = 500000,
    parameter logic [N-1:0]   REPEAT_EN       = {N{1'b0}}
) (
    input  logic                                clk5_i,
    input  logic                                reset_i,
    input  logic [N-1:0]                        raw_i,
    output logic [N-1:0]                        press_o,
    output logic [N-1:0]                        release_o,
    output logic [N-1:0]                        down_o,
    output logic                                key_valid_o,
    output logic [((N > 1) ? $clog2(N) : 1)-1:0] key_code_o
);

    localparam int KW   = (N > 1) ? $clog2(N) : 1;
    localparam int MAXV = (DEBOUNCE_CYCLES > REPEAT_DELAY)
                        ? ((DEBOUNCE_CYCLES > REPEAT_PERIOD) ? DEBOUNCE_CYCLES : REPEAT_PERIOD)
                        : ((REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD);
    localparam int CW   = $clog2(MAXV + 1);

    localparam logic [CW-1:0] DEB_LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] DLY_LAST = CW'(REPEAT_DELAY - 1);
    localparam logic [CW-1:0] PER_LAST = CW'(REPEAT_PERIOD - 1);
    localparam logic [CW-1:0] CNT_MAX  = {CW{1'b1}};
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] PRESS_DB = 2'd1;
    localparam logic [1:0] HELD     = 2'd2;
    localparam logic [1:0] REL_DB   = 2'd3;

    logic [N-1:0]  sync1_q, sync2_q;
    logic [1:0]    state_q [N];
    logic [1:0]    state_d [N];
    logic [CW-1:0] cnt_q   [N];
    logic [CW-1:0] cnt_d   [N];
    logic [N-1:0]  rep_q, rep_d;
    logic [N-1:0]  press_q, press_d;
    logic [N-1:0]  release_q, release_d;
    logic [N-1:0]  down_q, down_d;
    logic          key_valid_q, key_valid_d;
    logic [KW-1:0] key_code_q, key_code_d;

    function automatic logic [KW-1:0] lowest_index(input logic [N-1:0] v);
        logic [KW-1:0] idx;
        idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (v[i]) idx = KW'(i);
        end
        return idx;
    endfunction

    always_comb begin
        press_d   = '0;
        release_d = '0;
        down_d    = '0;
        rep_d     = rep_q;
        for (int i = 0; i < N; i++) begin
            state_d[i] = state_q[i];
            cnt_d[i]   = cnt_q[i];
            case (state_q[i])
                IDLE: begin
                    cnt_d[i] = '0;
                    if (sync2_q[i]) begin
                        state_d[i] = PRESS_DB;
                        press_d[i] = 1'b1;
                    end
                end
                PRESS_DB: begin
                    if (cnt_q[i] == DEB_LAST) begin
                        state_d[i] = HELD;
                        cnt_d[i]   = '0;
                    end else begin
                        cnt_d[i] = cnt_q[i] + CNT_ONE;
                    end
                end
                HELD: begin
                    // Release wins over a repeat that would fire in the same cycle.
                    if (!sync2_q[i]) begin
                        state_d[i]   = REL_DB;
                        cnt_d[i]     = '0;
                        release_d[i] = 1'b1;
                        rep_d[i]     = 1'b0;
                    end else if (REPEAT_EN[i] &&
                                 (cnt_q[i] == (rep_q[i] ? PER_LAST : DLY_LAST))) begin
                        press_d[i] = 1'b1;
                        cnt_d[i]   = '0;
                        rep_d[i]   = 1'b1;
                    end else if (cnt_q[i] != CNT_MAX) begin
                        cnt_d[i] = cnt_q[i] + CNT_ONE;
                    end
                end
                REL_DB: begin
                    if (cnt_q[i] == DEB_LAST) begin
                        state_d[i] = IDLE;
                        cnt_d[i]   = '0;
                    end else begin
                        cnt_d[i] = cnt_q[i] + CNT_ONE;
                    end
                end
                default: begin
                    state_d[i] = IDLE;
                    cnt_d[i]   = '0;
                    rep_d[i]   = 1'b0;
                end
            endcase
            down_d[i] = (state_d[i] == PRESS_DB) || (state_d[i] == HELD);
        end
        key_valid_d = |press_d;
        key_code_d  = lowest_index(press_d);
    end

    always_ff @(posedge clk5_i) begin
        if (reset_i) begin
            sync1_q     <= '0;
            sync2_q     <= '0;
            rep_q       <= '0;
            press_q     <= '0;
            release_q   <= '0;
            down_q      <= '0;
            key_valid_q <= 1'b0;
            key_code_q  <= '0;
            for (int i = 0; i < N; i++) begin
                state_q[i] <= IDLE;
                cnt_q[i]   <= '0;
            end
        end else begin
            sync1_q     <= raw_i;
            sync2_q     <= sync1_q;
            rep_q       <= rep_d;
            press_q     <= press_d;
            release_q   <= release_d;
            down_q      <= down_d;
            key_valid_q <= key_valid_d;
            key_code_q  <= key_code_d;
            for (int i = 0; i < N; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
        end
    end

    assign press_o     = press_q;
    assign release_o   = release_q;
    assign down_o      = down_q;
    assign key_valid_o = key_valid_q;
    assign key_code_o  = key_code_q;

endmodule

// File: tb/tb_multi_button_debounce.sv
// Directed bench for multi_button_debounce: N=4, 8-cycle debounce, repeat on channel 2.
module tb_multi_button_debounce;

    logic       clk5 = 1'b0;
    logic       reset;
    logic [3:0] raw;
    logic [3:0] press, rel, down;
    logic       key_valid;
    logic [1:0] key_code;

    int vectors     = 0;
    int miscompares = 0;
    int press_cnt [4];
    int rel_cnt   [4];
    logic [6:0] bnc = 7'b1010101;

    multi_button_debounce #(
        .N(4), .DEBOUNCE_CYCLES(8), .REPEAT_DELAY(20), .REPEAT_PERIOD(6),
        .REPEAT_EN(4'b0100)
    ) dut (
        .clk5_i(clk5), .reset_i(reset), .raw_i(raw),
        .press_o(press), .release_o(rel), .down_o(down),
        .key_valid_o(key_valid), .key_code_o(key_code)
    );

    always #5 clk5 = ~clk5;

    task automatic step();
        @(posedge clk5);
        #1;
        for (int i = 0; i < 4; i++) begin
            press_cnt[i] += int'(press[i]);
            rel_cnt[i]   += int'(rel[i]);
        end
    endtask

    task automatic clear_counts();
        for (int i = 0; i < 4; i++) begin
            press_cnt[i] = 0;
            rel_cnt[i]   = 0;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        reset = 1'b1;
        raw   = 4'b0000;
        clear_counts();
        step();
        step();
        chk("reset_press", 32'(press), 32'h0);
        chk("reset_release", 32'(rel), 32'h0);
        chk("reset_down", 32'(down), 32'h0);
        chk("reset_key", 32'({key_valid, key_code}), 32'h0);
        reset = 1'b0;
        for (int k = 0; k < 3; k++) step();

        // Bouncy press on channel 1
        clear_counts();
        for (int k = 0; k < 17; k++) begin
            raw    = 4'b0000;
            raw[1] = (k < 7) ? bnc[k] : 1'b1;
            step();
            if (k == 1) chk("t1_press_early", 32'(press), 32'h0);
            if (k == 2) begin
                chk("t1_press", 32'(press), 32'h2);
                chk("t1_down_rise", 32'(down), 32'h2);
                chk("t1_key_valid", 32'(key_valid), 32'h1);
                chk("t1_key_code", 32'(key_code), 32'h1);
            end
            if (k == 3) begin
                chk("t1_press_width", 32'(press), 32'h0);
                chk("t1_key_valid_off", 32'(key_valid), 32'h0);
            end
        end
        chk("t1_press_count", 32'(press_cnt[1]), 32'd1);
        chk("t1_down_held", 32'(down), 32'h2);

        // Bouncy release on channel 1
        clear_counts();
        for (int k = 0; k < 20; k++) begin
            raw    = 4'b0000;
            raw[1] = (k == 1) || (k == 3);
            step();
            if (k == 1) chk("t2_release_early", 32'(rel), 32'h0);
            if (k == 2) begin
                chk("t2_release", 32'(rel), 32'h2);
                chk("t2_down_fall", 32'(down), 32'h0);
            end
            if (k == 3) chk("t2_release_width", 32'(rel), 32'h0);
        end
        chk("t2_release_count", 32'(rel_cnt[1]), 32'd1);
        chk("t2_no_press", 32'(press_cnt[0] + press_cnt[1] + press_cnt[2] + press_cnt[3]), 32'd0);

        // Simultaneous press and release on channels 0 and 3
        clear_counts();
        for (int k = 0; k < 32; k++) begin
            raw = (k < 15) ? 4'b1001 : 4'b0000;
            step();
            if (k == 2) begin
                chk("t4_press", 32'(press), 32'h9);
                chk("t4_key_valid", 32'(key_valid), 32'h1);
                chk("t4_key_code", 32'(key_code), 32'h0);
            end
            if (k == 17) begin
                chk("t4_release", 32'(rel), 32'h9);
                chk("t4_down", 32'(down), 32'h0);
            end
        end

        // Hold-to-repeat on channel 2; release lands on a repeat slot
        clear_counts();
        for (int k = 0; k < 76; k++) begin
            raw = (k < 64) ? 4'b0100 : 4'b0000;
            step();
            if (k == 2)  chk("t3_press", 32'(press), 32'h4);
            if (k == 10) chk("t3_held_down", 32'(down), 32'h4);
            if (k == 29) chk("t3_before_rep1", 32'(press), 32'h0);
            if (k == 30) begin
                chk("t3_rep1", 32'(press), 32'h4);
                chk("t3_rep1_code", 32'({key_valid, key_code}), 32'h6);
            end
            if (k == 31) chk("t3_rep1_width", 32'(press), 32'h0);
            if (k == 36) chk("t3_rep2", 32'(press), 32'h4);
            if (k == 42) chk("t3_rep3", 32'(press), 32'h4);
            if (k == 48) chk("t3_rep4", 32'(press), 32'h4);
            if (k == 66) begin
                chk("t3_release", 32'(rel), 32'h4);
                chk("t3_no_rep_at_release", 32'(press), 32'h0);
            end
        end
        chk("t3_press_count", 32'(press_cnt[2]), 32'd7);
        chk("t3_release_count", 32'(rel_cnt[2]), 32'd1);

        // Reset while channel 2 is held
        raw = 4'b0100;
        for (int k = 0; k < 15; k++) step();
        clear_counts();
        reset = 1'b1;
        step();
        chk("t5_reset_press", 32'(press), 32'h0);
        chk("t5_reset_release", 32'(rel), 32'h0);
        chk("t5_reset_down", 32'(down), 32'h0);
        chk("t5_reset_key", 32'({key_valid, key_code}), 32'h0);
        reset = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            step();
            if (k == 1) chk("t5_down_after", 32'(down), 32'h0);
            if (k == 2) chk("t5_press_early", 32'(press), 32'h0);
            if (k == 3) chk("t5_fresh_press", 32'(press), 32'h4);
        end
        chk("t5_no_release", 32'(rel_cnt[2]), 32'd0);
        raw = 4'b0000;
        for (int k = 0; k < 30; k++) step();

        // One-cycle glitch on channel 3, then a re-press during the release lockout
        clear_counts();
        for (int k = 0; k < 24; k++) begin
            raw    = 4'b0000;
            raw[3] = (k == 0) || (k >= 12);
            step();
            if (k == 2)  chk("t6_press", 32'(press), 32'h8);
            if (k == 10) begin
                chk("t6_down_held", 32'(down), 32'h8);
                chk("t6_release_early", 32'(rel), 32'h0);
            end
            if (k == 11) begin
                chk("t6_release", 32'(rel), 32'h8);
                chk("t6_down_fall", 32'(down), 32'h0);
            end
            if (k == 19) chk("t6_lockout", 32'(press), 32'h0);
            if (k == 20) chk("t6_repress", 32'(press), 32'h8);
        end
        chk("t6_press_count", 32'(press_cnt[3]), 32'd2);
        chk("t6_release_count", 32'(rel_cnt[3]), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
